// File: rtl/csr_cmd_initiator.sv
// CSR request/response initiator: runs WRITE, READ and POLL commands one at a
// time against the CSR block and streams read/poll results back to the host.
module csr_cmd_initiator #(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned PollGap      = 4,
  parameter int unsigned PollTimeout  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              cmd_op_i,
  input  logic [RegAddrWidth-1:0] cmd_addr_i,
  input  logic [RegDataWidth-1:0] cmd_data_i,
  input  logic [RegDataWidth-1:0] cmd_cmp_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output logic [RegDataWidth-1:0] csr_req_data_o,
  output logic [RegAddrWidth-1:0] csr_req_addr_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [RegDataWidth-1:0] csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o,
  output logic [RegDataWidth-1:0] rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic                    busy_o,
  output logic                    poll_timeout_o
);

  localparam int unsigned AttW = $clog2(PollTimeout + 1);
  localparam int unsigned GapW = (PollGap > 1) ? $clog2(PollGap) : 1;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpPoll  = 2'b10;
  localparam logic [1:0] OpNop   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RSP,
    GAP,
    PUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic [RegDataWidth-1:0] mask_q, mask_d;
  logic [RegDataWidth-1:0] cmp_q, cmp_d;
  logic [RegDataWidth-1:0] req_data_q, req_data_d;
  logic                    req_write_q, req_write_d;
  logic [RegDataWidth-1:0] rd_data_q, rd_data_d;
  logic [AttW-1:0]         att_q, att_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic                    poll_to_q, poll_to_d;
  logic                    cmd_ready_q, busy_q, req_valid_q, rsp_ready_q, rd_valid_q;

  logic [AttW-1:0]         att_inc;
  logic                    match;

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    cmp_d       = cmp_q;
    req_data_d  = req_data_q;
    req_write_d = req_write_q;
    rd_data_d   = rd_data_q;
    att_d       = att_q;
    gap_d       = gap_q;
    poll_to_d   = poll_to_q;
    att_inc     = att_q + AttW'(1);
    match       = ((csr_rsp_data_i ^ cmp_q) & mask_q) == '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          op_d        = cmd_op_i;
          addr_d      = cmd_addr_i;
          mask_d      = cmd_data_i;
          cmp_d       = cmd_cmp_i;
          // Reads and polls put zero on the request data bus
          req_write_d = (cmd_op_i == OpWrite);
          req_data_d  = (cmd_op_i == OpWrite) ? cmd_data_i : '0;
          att_d       = '0;
          poll_to_d   = 1'b0;
          if (cmd_op_i != OpNop) state_d = REQ;
        end
      end
      REQ: begin
        if (csr_req_ready_i) state_d = (op_q == OpWrite) ? IDLE : RSP;
      end
      RSP: begin
        if (csr_rsp_valid_i) begin
          rd_data_d = csr_rsp_data_i;
          if (op_q != OpPoll) begin
            state_d = PUSH;
          end else begin
            att_d = att_inc;
            if (match) begin
              state_d = PUSH;
            end else if (att_inc == AttW'(PollTimeout)) begin
              poll_to_d = 1'b1;
              state_d   = PUSH;
            end else if (PollGap == 0) begin
              state_d = REQ;
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GapW'(PollGap - 1)) state_d = REQ;
        else gap_d = gap_q + GapW'(1);
      end
      PUSH: begin
        if (rd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latches and registered handshake outputs (decoded from next state)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      cmp_q       <= '0;
      req_data_q  <= '0;
      req_write_q <= 1'b0;
      rd_data_q   <= '0;
      att_q       <= '0;
      gap_q       <= '0;
      poll_to_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      cmp_q       <= cmp_d;
      req_data_q  <= req_data_d;
      req_write_q <= req_write_d;
      rd_data_q   <= rd_data_d;
      att_q       <= att_d;
      gap_q       <= gap_d;
      poll_to_q   <= poll_to_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      req_valid_q <= (state_d == REQ);
      rsp_ready_q <= (state_d == RSP);
      rd_valid_q  <= (state_d == PUSH);
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign csr_req_data_o  = req_data_q;
  assign csr_req_addr_o  = addr_q;
  assign csr_req_write_o = req_write_q;
  assign csr_req_valid_o = req_valid_q;
  assign csr_rsp_ready_o = rsp_ready_q;
  assign rd_data_o       = rd_data_q;
  assign rd_valid_o      = rd_valid_q;
  assign busy_o          = busy_q;
  assign poll_timeout_o  = poll_to_q;

endmodule

// File: tb/tb_csr_cmd_initiator.sv
// Directed bench for csr_cmd_initiator with a simple CSR target that answers
// each read one cycle after the request handshake.
module tb_csr_cmd_initiator;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_addr_i, cmd_data_i, cmd_cmp_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [31:0] csr_req_data_o, csr_req_addr_o;
  logic        csr_req_write_o, csr_req_valid_o, csr_req_ready_i;
  logic [31:0] csr_rsp_data_i;
  logic        csr_rsp_valid_i, csr_rsp_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, rd_ready_i, busy_o, poll_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int req_cnt, rdv_seen, last_hs, min_gap, rsp_idx;
  logic [31:0] rsp_tbl [16];

  csr_cmd_initiator #(
    .RegDataWidth(32), .RegAddrWidth(32), .PollGap(4), .PollTimeout(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_op_i(cmd_op_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .cmd_cmp_i(cmd_cmp_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .csr_req_data_o(csr_req_data_o), .csr_req_addr_o(csr_req_addr_o),
    .csr_req_write_o(csr_req_write_o), .csr_req_valid_o(csr_req_valid_o),
    .csr_req_ready_i(csr_req_ready_i), .csr_rsp_data_i(csr_rsp_data_i),
    .csr_rsp_valid_i(csr_rsp_valid_i), .csr_rsp_ready_o(csr_rsp_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .poll_timeout_o(poll_timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock (negedge to negedge) and run the target model
  task automatic cycle();
    bit hs_req, hs_wr, hs_rsp;
    hs_req = csr_req_valid_o && csr_req_ready_i;
    hs_wr  = csr_req_write_o;
    hs_rsp = csr_rsp_valid_i && csr_rsp_ready_o;
    if (rd_valid_o) rdv_seen++;
    @(negedge clk_i);
    cyc++;
    if (hs_rsp) csr_rsp_valid_i = 1'b0;
    if (hs_req) begin
      req_cnt++;
      if (last_hs >= 0 && (cyc - last_hs - 1) < min_gap) min_gap = cyc - last_hs - 1;
      last_hs = cyc;
      if (!hs_wr) begin
        csr_rsp_valid_i = 1'b1;
        csr_rsp_data_i  = rsp_tbl[rsp_idx];
        rsp_idx = (rsp_idx + 1) % 16;
      end
    end
  endtask

  task automatic clear_stats();
    req_cnt = 0; rdv_seen = 0; last_hs = -1; min_gap = 999; rsp_idx = 0;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] c);
    cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d; cmd_cmp_i = c;
    cmd_valid_i = 1'b1;
    cycle();
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({cmd_ready_o, busy_o, csr_req_valid_o, csr_rsp_ready_o, rd_valid_o, poll_timeout_o,
         csr_req_write_o} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 1000000", {cmd_ready_o, busy_o,
        csr_req_valid_o, csr_rsp_ready_o, rd_valid_o, poll_timeout_o, csr_req_write_o});
    end
    n_tests++;
    if ({csr_req_addr_o, csr_req_data_o, rd_data_o} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h exp 0", {csr_req_addr_o, csr_req_data_o, rd_data_o});
    end
    rst_ni = 1'b1;
    cycle(); cycle();
    n_tests++;
    if ({cmd_ready_o, busy_o} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release got %b exp 10", {cmd_ready_o, busy_o});
    end
  endtask

  task automatic test_write();
    clear_stats();
    send(2'b00, 32'h1, 32'hDEADBEEF, 32'h0);
    n_tests++;
    if ({csr_req_valid_o, csr_req_write_o, csr_req_addr_o, csr_req_data_o, cmd_ready_o}
        !== {1'b1, 1'b1, 32'h1, 32'hDEADBEEF, 1'b0}) begin
      n_fail++; $display("FAIL wr_req got %b %b %h %h %b exp 1 1 1 deadbeef 0", csr_req_valid_o,
        csr_req_write_o, csr_req_addr_o, csr_req_data_o, cmd_ready_o);
    end
    cycle();
    n_tests++;
    if ({csr_req_valid_o, cmd_ready_o, busy_o} !== 3'b010) begin
      n_fail++; $display("FAIL wr_done got %b exp 010", {csr_req_valid_o, cmd_ready_o, busy_o});
    end
    repeat (4) cycle();
    n_tests++;
    if (req_cnt !== 1 || rdv_seen !== 0) begin
      n_fail++; $display("FAIL wr_counts got req=%0d rdv=%0d exp req=1 rdv=0", req_cnt, rdv_seen);
    end
  endtask

  task automatic test_read();
    clear_stats();
    rsp_tbl[0] = 32'h5;
    rd_ready_i = 1'b0;
    send(2'b01, 32'h2, 32'hFFFF_FFFF, 32'h0);
    n_tests++;
    if ({csr_req_valid_o, csr_req_write_o, csr_req_addr_o, csr_req_data_o}
        !== {1'b1, 1'b0, 32'h2, 32'h0}) begin
      n_fail++; $display("FAIL rd_req got %b %b %h %h exp 1 0 2 0", csr_req_valid_o,
        csr_req_write_o, csr_req_addr_o, csr_req_data_o);
    end
    cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({rd_valid_o, rd_data_o} !== {1'b1, 32'h5}) begin
        n_fail++; $display("FAIL rd_hold%0d got %b %h exp 1 5", i, rd_valid_o, rd_data_o);
      end
      if (i < 2) cycle();
    end
    rd_ready_i = 1'b1;
    cycle();
    n_tests++;
    if ({rd_valid_o, busy_o, cmd_ready_o} !== 3'b001) begin
      n_fail++; $display("FAIL rd_drop got %b exp 001", {rd_valid_o, busy_o, cmd_ready_o});
    end
  endtask

  task automatic test_poll_match();
    clear_stats();
    rsp_tbl[0] = 32'h2; rsp_tbl[1] = 32'h2; rsp_tbl[2] = 32'h0;
    rd_ready_i = 1'b1;
    send(2'b10, 32'h0, 32'h2, 32'h0);
    for (int i = 0; i < 200 && !rd_valid_o; i++) cycle();
    n_tests++;
    if ({rd_valid_o, rd_data_o, poll_timeout_o} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL poll_result got %b %h %b exp 1 0 0", rd_valid_o, rd_data_o,
        poll_timeout_o);
    end
    n_tests++;
    if (req_cnt !== 3 || min_gap < 4) begin
      n_fail++; $display("FAIL poll_reqs got req=%0d gap=%0d exp req=3 gap>=4", req_cnt, min_gap);
    end
    cycle();
  endtask

  task automatic test_poll_timeout();
    clear_stats();
    for (int i = 0; i < 16; i++) rsp_tbl[i] = 32'h100 + 32'(i);
    send(2'b10, 32'h4, 32'hFFFF_FFFF, 32'h0);
    for (int i = 0; i < 300 && !rd_valid_o; i++) cycle();
    n_tests++;
    if ({rd_valid_o, rd_data_o, poll_timeout_o} !== {1'b1, 32'h107, 1'b1}) begin
      n_fail++; $display("FAIL to_result got %b %h %b exp 1 107 1", rd_valid_o, rd_data_o,
        poll_timeout_o);
    end
    n_tests++;
    if (req_cnt !== 8) begin
      n_fail++; $display("FAIL to_reqs got %0d exp 8", req_cnt);
    end
    cycle(); cycle();
    n_tests++;
    if ({poll_timeout_o, busy_o} !== 2'b10) begin
      n_fail++; $display("FAIL to_sticky got %b exp 10", {poll_timeout_o, busy_o});
    end
    send(2'b11, 32'h0, 32'h0, 32'h0);
    n_tests++;
    if ({poll_timeout_o, busy_o, cmd_ready_o, csr_req_valid_o} !== 4'b0010) begin
      n_fail++; $display("FAIL nop_clear got %b exp 0010", {poll_timeout_o, busy_o, cmd_ready_o,
        csr_req_valid_o});
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    csr_req_ready_i = 1'b0;
    send(2'b00, 32'h33, 32'hA5A5_5A5A, 32'h0);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({csr_req_valid_o, csr_req_write_o, csr_req_addr_o, csr_req_data_o}
          !== {1'b1, 1'b1, 32'h33, 32'hA5A5_5A5A}) begin
        n_fail++; $display("FAIL bp_hold%0d got %b %b %h %h exp 1 1 33 a5a55a5a", i,
          csr_req_valid_o, csr_req_write_o, csr_req_addr_o, csr_req_data_o);
      end
      cycle();
    end
    csr_req_ready_i = 1'b1;
    cycle();
    repeat (2) cycle();
    n_tests++;
    if (req_cnt !== 1 || csr_req_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_single got req=%0d valid=%b exp 1 0", req_cnt, csr_req_valid_o);
    end
    csr_rsp_valid_i = 1'b1; csr_rsp_data_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if ({busy_o, csr_rsp_ready_o, rd_valid_o, cmd_ready_o, rd_data_o}
          !== {4'b0001, 32'h107}) begin
        n_fail++; $display("FAIL spurious%0d got %b %h exp 0001 107", i,
          {busy_o, csr_rsp_ready_o, rd_valid_o, cmd_ready_o}, rd_data_o);
      end
    end
    csr_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset_in_gap();
    clear_stats();
    for (int i = 0; i < 16; i++) rsp_tbl[i] = 32'h1;
    send(2'b10, 32'h8, 32'hFFFF_FFFF, 32'h0);
    cycle(); cycle(); cycle();
    n_tests++;
    if ({busy_o, csr_req_valid_o, csr_rsp_ready_o} !== 3'b100) begin
      n_fail++; $display("FAIL gap_state got %b exp 100", {busy_o, csr_req_valid_o, csr_rsp_ready_o});
    end
    rst_ni = 1'b0;
    csr_rsp_valid_i = 1'b0;
    #1;
    n_tests++;
    if ({cmd_ready_o, busy_o, csr_req_valid_o, csr_rsp_ready_o, rd_valid_o, poll_timeout_o,
         csr_req_write_o, csr_req_addr_o, rd_data_o} !== {7'b1000000, 64'h0}) begin
      n_fail++; $display("FAIL rst_gap got %b %h %h exp 1000000 0 0", {cmd_ready_o, busy_o,
        csr_req_valid_o, csr_rsp_ready_o, rd_valid_o, poll_timeout_o, csr_req_write_o},
        csr_req_addr_o, rd_data_o);
    end
    cycle(); cycle();
    rst_ni = 1'b1;
    cycle();
    n_tests++;
    if ({cmd_ready_o, busy_o, csr_req_valid_o} !== 3'b100) begin
      n_fail++; $display("FAIL rst_release got %b exp 100", {cmd_ready_o, busy_o, csr_req_valid_o});
    end
    clear_stats();
    send(2'b10, 32'h8, 32'hFFFF_FFFF, 32'h0);
    for (int i = 0; i < 300 && !rd_valid_o; i++) cycle();
    n_tests++;
    if (req_cnt !== 8 || {rd_valid_o, rd_data_o, poll_timeout_o} !== {1'b1, 32'h1, 1'b1}) begin
      n_fail++; $display("FAIL repoll got req=%0d %b %h %b exp 8 1 1 1", req_cnt, rd_valid_o,
        rd_data_o, poll_timeout_o);
    end
    cycle();
  endtask

  initial begin
    rst_ni = 1'b0;
    cmd_op_i = 2'b11; cmd_addr_i = '0; cmd_data_i = '0; cmd_cmp_i = '0; cmd_valid_i = 1'b0;
    csr_req_ready_i = 1'b1; csr_rsp_data_i = '0; csr_rsp_valid_i = 1'b0; rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) rsp_tbl[i] = '0;
    clear_stats();
    repeat (2) @(negedge clk_i);
    test_reset();
    test_write();
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_backpressure();
    test_reset_in_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
